// File: rtl/ext_cap_list_walker.sv
`default_nettype none
// ============================================================================
// Module      : ext_cap_list_walker
// Description : Walks the PCI Express Extended Capability list from 0x100 and
//               reports the offset and version of the requested capability ID.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_cap_list_walker #(
    parameter int REGISTER_WIDTH = 32,
    parameter int MAX_HOPS       = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [15:0]               target_cap_id,
    output logic                      rd_req,
    output logic [11:0]               rd_addr,
    input  logic                      rd_ack,
    input  logic [REGISTER_WIDTH-1:0] rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic [11:0]               found_offset,
    output logic [3:0]                found_version,
    output logic                      error
);

    localparam int              HOP_W       = $clog2(MAX_HOPS + 1);
    localparam logic [HOP_W-1:0] c_max_hops  = HOP_W'(MAX_HOPS);
    localparam logic [11:0]     c_list_head = 12'h100;
    localparam logic [31:0]     c_no_device = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_target;
    logic [11:0]      r_offset;
    logic [HOP_W-1:0] r_hops;
    logic [31:0]      r_hdr;
    logic             r_found;
    logic [11:0]      r_found_offset;
    logic [3:0]       r_found_version;
    logic             r_error;

    logic             w_accept;
    logic             w_take;
    logic             w_hit;
    logic             w_fail;
    logic             w_advance;
    logic [11:0]      w_next_ptr;
    logic [15:0]      w_hdr_id;
    logic [3:0]       w_hdr_ver;

    // Bits [21:20] of the next pointer are reserved; forcing them to zero
    // also keeps every followed pointer dword aligned.
    assign w_next_ptr = {r_hdr[31:22], 2'b00};
    assign w_hdr_id   = r_hdr[15:0];
    assign w_hdr_ver  = r_hdr[19:16];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_take      = 1'b0;
        w_hit       = 1'b0;
        w_fail      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (rd_ack) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                // First matching rule wins; only the fall-through continues the walk.
                w_state_nxt = S_DONE;
                if (r_hdr == c_no_device) begin
                    w_fail = 1'b1;
                end else if ((r_hdr == 32'd0) && (r_offset == c_list_head)) begin
                    w_fail = 1'b0;
                end else if (w_hdr_id == r_target) begin
                    w_hit = 1'b1;
                end else if (w_next_ptr == 12'd0) begin
                    w_fail = 1'b0;
                end else if (w_next_ptr < c_list_head) begin
                    w_fail = 1'b1;
                end else if (r_hops == c_max_hops) begin
                    w_fail = 1'b1;
                end else begin
                    w_advance   = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target        <= 16'd0;
            r_offset        <= 12'd0;
            r_hops          <= '0;
            r_hdr           <= 32'd0;
            r_found         <= 1'b0;
            r_found_offset  <= 12'd0;
            r_found_version <= 4'd0;
            r_error         <= 1'b0;
        end else begin
            if (w_accept) begin
                r_target        <= target_cap_id;
                r_offset        <= c_list_head;
                r_hops          <= '0;
                r_found         <= 1'b0;
                r_found_offset  <= 12'd0;
                r_found_version <= 4'd0;
                r_error         <= 1'b0;
            end
            if (w_take) begin
                r_hdr  <= rd_data[31:0];
                r_hops <= r_hops + 1'b1;
            end
            if (w_advance) begin
                r_offset <= w_next_ptr;
            end
            if (w_hit) begin
                r_found         <= 1'b1;
                r_found_offset  <= r_offset;
                r_found_version <= w_hdr_ver;
            end
            if (w_fail) begin
                r_error <= 1'b1;
            end
        end
    end

    assign rd_req        = (r_state == S_REQ);
    assign rd_addr       = r_offset;
    assign busy          = (r_state == S_REQ) || (r_state == S_CHECK);
    assign done          = (r_state == S_DONE);
    assign found         = r_found;
    assign found_offset  = r_found_offset;
    assign found_version = r_found_version;
    assign error         = r_error;

endmodule
`default_nettype wire
